sub_shift_rows: RTL and testbench



---
 rtl/sub_shift_rows_if.sv | 20 ++
 rtl/sub_shift_rows.sv | 208 ++++++++++++++++++++
 tb/tb_sub_shift_rows.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_shift_rows_if.sv
// Valid/ready bundle for sub_shift_rows: a 128-bit AES state in, the substituted and shifted state out.
interface sub_shift_rows_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inv_en;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, inv_en, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, inv_en, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes/InvSubBytes + ShiftRows/InvShiftRows, LANES bytes substituted per cycle.
// Optional AES_SBOX_PIPE_EN registers the S-box outputs, adding one cycle to the SUB phase.

module sub_bytes (
  input  logic [7:0] din_i,
  input  logic       inv_en_i,
  output logic [7:0] dout_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the GF(2^8) inverse and conveniently maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv_aff;
  logic [7:0] gf_in;
  logic [7:0] gf_out;

  // One shared inverter: decrypt undoes the affine map first, encrypt applies it last.
  assign inv_aff = rotl(din_i, 1) ^ rotl(din_i, 3) ^ rotl(din_i, 6) ^ 8'h05;
  assign gf_in   = inv_en_i ? inv_aff : din_i;
  assign gf_out  = gf_inv(gf_in);
  assign dout_o  = inv_en_i ? gf_out
                            : (gf_out ^ rotl(gf_out, 1) ^ rotl(gf_out, 2) ^
                               rotl(gf_out, 3) ^ rotl(gf_out, 4) ^ 8'h63);
endmodule

module sub_shift_rows #(
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_shift_rows_if.slave bus
);
  localparam int NGRP = 16 / LANES;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_shift_rows: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, SUB, OUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inv_q, inv_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  out_state_q, out_state_d;
  logic [7:0]    sbuf_q [16];
  logic [7:0]    sbuf_d [16];

  logic          accept;
  logic          done;
  logic          wr_en;
  logic [CW-1:0] wr_grp;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  logic [7:0]    wr_data  [LANES];
  logic [127:0]  shifted_state;

  assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = sbuf_q[4'(int'(cnt_q) * LANES + l)];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_bytes u_sub_bytes (
      .din_i    (lane_in[l]),
      .inv_en_i (inv_q),
      .dout_o   (lane_out[l])
    );
  end

`ifdef AES_SBOX_PIPE_EN
  logic [7:0]    sub_q [LANES];
  logic          pend_q;
  logic [CW-1:0] wb_grp_q;

  // Group issued in one cycle is written back the next; pend_q marks a result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      wb_grp_q <= '0;
      for (int l = 0; l < LANES; l++) sub_q[l] <= 8'h00;
    end else begin
      pend_q   <= (state_q == SUB) && !done;
      wb_grp_q <= cnt_q;
      sub_q    <= lane_out;
    end
  end

  assign wr_en   = (state_q == SUB) && pend_q;
  assign wr_grp  = wb_grp_q;
  assign wr_data = sub_q;
  assign done    = wr_en && (wb_grp_q == LAST);
`else
  assign wr_en   = (state_q == SUB);
  assign wr_grp  = cnt_q;
  assign wr_data = lane_out;
  assign done    = wr_en && (cnt_q == LAST);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sbuf_d = sbuf_q;
    if (accept) begin
      for (int i = 0; i < 16; i++) sbuf_d[i] = bus.in_state[127 - 8*i -: 8];
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) sbuf_d[4'(int'(wr_grp) * LANES + l)] = wr_data[l];
    end
  end

  // Shift reads sbuf_d so the group completed this cycle is already included.
  always_comb begin
    shifted_state = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_state[127 - 8*(4*c + r) -: 8] =
          sbuf_d[4'(4 * (inv_q ? ((c - r) & 3) : ((c + r) & 3)) + r)];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = SUB;
      SUB:     if (done)          state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    inv_d       = inv_q;
    out_state_d = out_state_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          inv_d = bus.inv_en;
        end
      end
      SUB: begin
        cnt_d = (done || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (done) out_state_d = shifted_state;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      // NOTE: the state buffer is reset too, so a discarded partial state can never leak out.
      for (int i = 0; i < 16; i++) sbuf_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      sbuf_q      <= sbuf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
endmodule

// File: tb/tb_sub_shift_rows.sv
// Self-checking bench: three sub_shift_rows instances (LANES 4, 1, 16) driven in lockstep
// against a table-based AES reference model.
module tb_sub_shift_rows;
  localparam int NDUT = 3;
`ifdef AES_SBOX_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  typedef struct {
    logic [127:0] in_state;
    logic         inv;
    logic [127:0] exp_state;
  } vec_t;

  function automatic int lanes_of(int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : 16;
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         inv_en;
  logic         out_ready;
  logic [127:0] in_state;
  logic         in_ready_w  [NDUT];
  logic         out_valid_w [NDUT];
  logic [127:0] out_state_w [NDUT];

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = lanes_of(g);
    sub_shift_rows_if ifc ();
    assign ifc.in_valid    = in_valid;
    assign ifc.in_state    = in_state;
    assign ifc.inv_en      = inv_en;
    assign ifc.out_ready   = out_ready;
    assign in_ready_w[g]   = ifc.in_ready;
    assign out_valid_w[g]  = ifc.out_valid;
    assign out_state_w[g]  = ifc.out_state;
    sub_shift_rows #(.LANES(L)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    logic [7:0] inv;
    logic [7:0] s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[3'(i + 4)] ^ inv[3'(i + 5)] ^ inv[3'(i + 6)] ^ inv[3'(i + 7)] ^ c[i];
      sbox_t[a]  = s;
      isbox_t[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] st, input logic inv);
    logic [7:0]   m [4][4];
    logic [127:0] r;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        m[row][col] = inv ? isbox_t[st[127 - 8*(4*col + row) -: 8]]
                          : sbox_t[st[127 - 8*(4*col + row) -: 8]];
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*col + row) -: 8] = m[row][inv ? (col - row + 4) % 4 : (col + row) % 4];
    return r;
  endfunction

  function automatic logic all_ready();
    logic ok;
    ok = 1'b1;
    for (int g = 0; g < NDUT; g++) ok = ok & in_ready_w[g];
    return ok;
  endfunction

  // Returns at the falling edge just after the accepting edge; in_valid stays high with junk.
  task automatic send(input string name, input logic [127:0] st, input logic inv);
    for (int n = 0; n < 50 && !all_ready(); n++) @(negedge clk);
    check({name, "_ready"}, all_ready(), 1'b1);
    in_valid = 1'b1;
    in_state = st;
    inv_en   = inv;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("%s_accept_L%0d", name, lanes_of(g)), in_ready_w[g], 1'b0);
    in_state = ~st;
    inv_en   = ~inv;
  endtask

  task automatic collect(input string name, input logic [127:0] exp);
    int lat [NDUT];
    int done_n;
    done_n = 0;
    for (int g = 0; g < NDUT; g++) lat[g] = 0;
    for (int k = 1; k <= 40 && done_n < NDUT; k++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (lat[g] == 0 && out_valid_w[g]) begin
          lat[g] = k;
          done_n++;
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s_lat_L%0d", name, lanes_of(g)), 128'(lat[g]), 128'(16 / lanes_of(g) + PIPE));
      check($sformatf("%s_state_L%0d", name, lanes_of(g)), out_state_w[g], exp);
    end
  endtask

  task automatic hold_check(input string name, input logic [127:0] exp, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("%s_hold_valid_L%0d", name, lanes_of(g)), out_valid_w[g], 1'b1);
        check($sformatf("%s_hold_ready_L%0d", name, lanes_of(g)), in_ready_w[g], 1'b0);
        check($sformatf("%s_hold_state_L%0d", name, lanes_of(g)), out_state_w[g], exp);
      end
    end
  endtask

  task automatic release_out(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s_drop_valid_L%0d", name, lanes_of(g)), out_valid_w[g], 1'b0);
      check($sformatf("%s_idle_ready_L%0d", name, lanes_of(g)), in_ready_w[g], 1'b1);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [127:0] st, input logic inv,
                         input logic [127:0] exp, input int stall);
    send(name, st, inv);
    collect(name, exp);
    hold_check(name, exp, stall);
    release_out(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [4];
    logic [127:0] st;
    logic         inv;
    int           stale;

    vecs[0] = '{in_state: 128'h193de3bea0f4e22b9ac68d2ae9f84808, inv: 1'b0,
                exp_state: 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{in_state: 128'hd4bf5d30e0b452aeb84111f11e2798e5, inv: 1'b1,
                exp_state: 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[2] = '{in_state: {16{8'h00}}, inv: 1'b0, exp_state: {16{8'h63}}};
    vecs[3] = '{in_state: {16{8'h00}}, inv: 1'b1, exp_state: {16{8'h52}}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inv_en    = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    build_tables();

    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_in_ready_L%0d", lanes_of(g)), in_ready_w[g], 1'b0);
      check($sformatf("rst_out_valid_L%0d", lanes_of(g)), out_valid_w[g], 1'b0);
      check($sformatf("rst_out_state_L%0d", lanes_of(g)), out_state_w[g], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("post_rst_ready_L%0d", lanes_of(g)), in_ready_w[g], 1'b1);

    for (int v = 0; v < 4; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].in_state, vecs[v].inv, vecs[v].exp_state, 0);

    // Backpressure: 10 stalled cycles while the next state waits on in_valid.
    send("bp", vecs[0].in_state, vecs[0].inv);
    collect("bp", vecs[0].exp_state);
    in_valid = 1'b1;
    in_state = vecs[2].in_state;
    inv_en   = vecs[2].inv;
    hold_check("bp", vecs[0].exp_state, 10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("bp_release_valid_L%0d", lanes_of(g)), out_valid_w[g], 1'b0);
      check($sformatf("bp_not_yet_accepted_L%0d", lanes_of(g)), in_ready_w[g], 1'b1);
    end
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("bp_next_accept_L%0d", lanes_of(g)), in_ready_w[g], 1'b0);
    in_valid = 1'b0;
    collect("bp_next", vecs[2].exp_state);
    release_out("bp_next");

    // Reset in the middle of SUB: LANES=4 instance sits at cnt=2.
    send("rst_mid", vecs[1].in_state, vecs[1].inv);
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst_mid_valid_L%0d", lanes_of(g)), out_valid_w[g], 1'b0);
      check($sformatf("rst_mid_ready_L%0d", lanes_of(g)), in_ready_w[g], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("rst_mid_rel_ready_L%0d", lanes_of(g)), in_ready_w[g], 1'b1);
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) if (out_valid_w[g] !== 1'b0) stale++;
    end
    check("rst_mid_no_stale_output", 128'(stale), 128'(0));
    run_txn("rst_mid_after", vecs[0].in_state, vecs[0].inv, vecs[0].exp_state, 0);

    for (int t = 0; t < 20; t++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      run_txn($sformatf("rand%0d", t), st, inv, ref_model(st, inv), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
